// File: rtl/sub_result_checker_if.sv
// rtl/sub_result_checker_if.sv - operand-pair handshake between stimulus source and checker
interface sub_result_checker_if #(
  parameter int WIDTH = 8
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;

  modport master (output valid, output num1, output num2, input ready);
  modport slave  (input valid, input num1, input num2, output ready);
endinterface

// File: rtl/sub_result_checker.sv
// rtl/sub_result_checker.sv - drives operand pairs onto a subtractor and checks its settled result
module sub_result_checker #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sub_result_checker_if.slave  in_if,
  output logic [WIDTH-1:0]     dut_num1_o,
  output logic [WIDTH-1:0]     dut_num2_o,
  input  logic [WIDTH:0]       dut_sout_i,
  input  logic                 clear_i,
  output logic                 res_valid_o,
  output logic                 res_pass_o,
  output logic [WIDTH:0]       expected_o,
  output logic [CNT_W-1:0]     pass_count_o,
  output logic [CNT_W-1:0]     fail_count_o,
  output logic                 sticky_err_o
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE} state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] num1_q, num1_d, num2_q, num2_d;
  logic [WIDTH:0]   exp_q, exp_d;
  logic             res_valid_q, res_valid_d, res_pass_q, res_pass_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             sticky_q, sticky_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num1_q      <= '0;
      num2_q      <= '0;
      exp_q       <= '0;
      res_valid_q <= 1'b0;
      res_pass_q  <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      exp_q       <= exp_d;
      res_valid_q <= res_valid_d;
      res_pass_q  <= res_pass_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      sticky_q    <= sticky_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    exp_d       = exp_q;
    res_valid_d = 1'b0;
    res_pass_d  = res_pass_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    sticky_d    = sticky_q;
    case (state_q)
      IDLE: begin
        if (in_if.valid) begin
          num1_d  = in_if.num1;
          num2_d  = in_if.num2;
          exp_d   = {1'b0, in_if.num1} + {1'b0, ~in_if.num2} + (WIDTH + 1)'(1);
          cnt_d   = SC_W'(SETTLE_CYCLES);
          state_d = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - SC_W'(1);
        if (cnt_q <= SC_W'(1)) state_d = COMPARE;
      end
      COMPARE: begin
        res_valid_d = 1'b1;
        res_pass_d  = (dut_sout_i == exp_q);
        // Counters stick at all-ones rather than wrapping back to a misleading small value
        if (res_pass_d) begin
          if (pass_q != {CNT_W{1'b1}}) pass_d = pass_q + CNT_W'(1);
        end else begin
          if (fail_q != {CNT_W{1'b1}}) fail_d = fail_q + CNT_W'(1);
          sticky_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      pass_d   = '0;
      fail_d   = '0;
      sticky_d = 1'b0;
    end
  end

  // Gate with rst so the source sees not-ready for the whole reset window
  assign in_if.ready  = (state_q == IDLE) && !rst_i;
  assign dut_num1_o   = num1_q;
  assign dut_num2_o   = num2_q;
  assign expected_o   = exp_q;
  assign res_valid_o  = res_valid_q;
  assign res_pass_o   = res_pass_q;
  assign pass_count_o = pass_q;
  assign fail_count_o = fail_q;
  assign sticky_err_o = sticky_q;

endmodule
